cache_write_buffer: RTL
=======================

# cache_write_buffer

Posted-write buffer between the data-cache memory port and port 1 of the data RAM mux. Absorbs write-through traffic from the cache in a small FIFO, acknowledging each write in one cycle, and drains entries to memory in order. Reads pass through to memory only once read-after-write ordering is guaranteed. The default is to drain the buffer first; bypass past non-conflicting entries is optional.

## Interface
Parameters:
- DEPTH, 4: buffer entries; power of two, ≥2.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; BE width = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- up_req_i / up_gnt_o  in/out  1  cache-side request and grant.
- up_addr_i  in  ADDR_WIDTH  cache-side address.
- up_we_i  in  1  cache-side write enable.
- up_be_i  in  DATA_WIDTH/8  cache-side byte enables.
- up_wdata_i  in  DATA_WIDTH  cache-side write data.
- up_rvalid_o  out  1  response valid, one per granted request.
- up_rdata_o  out  DATA_WIDTH  read data, valid with up_rvalid_o.
- mem_req_o / mem_gnt_i  out/in  1  RAM-mux request and grant.
- mem_addr_o  out  ADDR_WIDTH  RAM-mux address.
- mem_we_o  out  1  RAM-mux write enable.
- mem_be_o  out  DATA_WIDTH/8  RAM-mux byte enables.
- mem_wdata_o  out  DATA_WIDTH  RAM-mux write data.
- mem_rvalid_i  in  1  RAM-mux response valid.
- mem_rdata_i  in  DATA_WIDTH  RAM-mux read data.
- wb_empty_o  out  1  buffer empty and no write in flight (fence indication).

## Operation
- Protocol on both sides: req held with stable addr/we/be/wdata until gnt; exactly one rvalid per grant, no earlier than the next cycle.
- Upstream write: up_gnt_o = up_req_i & up_we_i & (count < DEPTH), combinational. No accept-on-pop: a full buffer stalls even if an entry leaves that cycle. The entry {addr, be, wdata} is pushed at the tail, and up_rvalid_o pulses the next cycle.
- Upstream read: granted only as pass-through, so up_gnt_o = mem_gnt_i in the cycle the read is presented downstream. up_rvalid_o and up_rdata_o mirror mem_rvalid_i and mem_rdata_i for that read.
- Downstream FSM:
  - IDLE
    - Read pending and eligible: present it downstream (mem_we_o=0), with priority over draining; on mem_gnt_i → RD_WAIT.
    - Otherwise, if count>0: present the head entry (mem_we_o=1); on mem_gnt_i pop the head → WR_WAIT.
  - RD_WAIT: on mem_rvalid_i → IDLE.
  - WR_WAIT: on mem_rvalid_i → IDLE. This rvalid is swallowed and never forwarded upstream.
- Read eligibility (without macro): count==0 and state IDLE.
- Pointers: DEPTH-entry circular buffer, log2(DEPTH)-bit head/tail with wrap, count 0..DEPTH. Push and pop in the same cycle leave count unchanged.
- wb_empty_o = (count==0) & (state != WR_WAIT).

## Timing
- Reset values: all outputs 0 except wb_empty_o=1; count, pointers and state cleared (IDLE); entry storage need not be reset.
- Reset mid-operation: buffered writes are discarded. A mem_rvalid_i arriving after reset is ignored and produces no up_rvalid_o.
- Write ack latency: gnt in cycle N, up_rvalid_o in N+1.
- Drain: one write per 2 cycles minimum with the single-cycle-rvalid RAM mux (gnt, then rvalid).
- At most one downstream transaction outstanding; a new mem_req_o can be raised only in IDLE, i.e. the cycle after rvalid.
- Only one upstream grant per cycle, so write-ack and read-rvalid never coincide.
- mem_* request outputs are combinational from state, head entry and up_* (read case); they are stable while mem_req_o=1 and mem_gnt_i=0.

## Configuration
- CACHE_WB_BYPASS_EN
  - Defined: a read is eligible in IDLE when no valid entry matches its word address (addr[ADDR_WIDTH-1:2] compared against all occupied entries, byte enables ignored). An entry in WR_WAIT has already been granted and needs no check.
  - Undefined: reads wait until wb_empty_o=1.

## Test plan
- Single write 0x0010_0000 ← 0x1234_ABCD, be=1111 -> up_gnt_o same cycle, up_rvalid_o next cycle; mem write with identical addr/data/be appears within 2 cycles; wb_empty_o returns to 1 after mem rvalid.
- Burst of 5 back-to-back writes, DEPTH=4, addresses 0x0..0x10 -> first 4 granted consecutively; 5th stalls until count<4; memory receives all 5 in order; count wraps correctly.
- Write 0x0010_0000 ← 0xDEAD_BEEF, then read 0x0010_0000 -> read granted only after the write's mem rvalid; up_rdata_o = 0xDEAD_BEEF.
- Bypass (macro defined): 3 writes to 0x100–0x108 buffered, read 0x200 -> read issued before the remaining drain; with macro undefined, the read waits for all 3.
- Reset asserted with 3 entries buffered and a write in WR_WAIT -> next cycle all outputs at reset values; late mem_rvalid_i produces no up_rvalid_o; no further mem writes.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Posted-write buffer between the data-cache port and the data RAM mux: single-cycle write acks, in-order drain, ordered reads.
// Optional CACHE_WB_BYPASS_EN lets reads overtake buffered writes to other word addresses.
module cache_write_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_req_i,
  output logic                    up_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   up_addr_i,
  input  logic                    up_we_i,
  input  logic [DATA_WIDTH/8-1:0] up_be_i,
  input  logic [DATA_WIDTH-1:0]   up_wdata_i,
  output logic                    up_rvalid_o,
  output logic [DATA_WIDTH-1:0]   up_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    wb_empty_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        count;
  logic                    wr_ack;
  logic [ADDR_WIDTH-1:0]   addr_mem [DEPTH];
  logic [BE_WIDTH-1:0]     be_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

  logic buf_empty;
  logic buf_full;
  logic wr_gnt;
  logic rd_pending;
  logic rd_eligible;
  logic rd_sel;
  logic wr_sel;
  logic push;
  logic pop;
  logic rd_resp;

  assign buf_empty  = (count == '0);
  assign buf_full   = (count == CNT_W'(DEPTH));
  assign wr_gnt     = up_req_i & up_we_i & ~buf_full;
  assign rd_pending = up_req_i & ~up_we_i;

`ifdef CACHE_WB_BYPASS_EN
  logic             addr_hit;
  logic [PTR_W-1:0] off;
  logic             wr_hold;

  always_comb begin
    addr_hit = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head;
      if ((CNT_W'(off) < count) &&
          (addr_mem[i][ADDR_WIDTH-1:2] == up_addr_i[ADDR_WIDTH-1:2]))
        addr_hit = 1'b1;
    end
  end

  // A head write already presented but not yet granted keeps the port, so mem_* stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) wr_hold <= 1'b0;
    else        wr_hold <= wr_sel & ~mem_gnt_i;
  end

  assign rd_eligible = (state == IDLE) & ~addr_hit & ~wr_hold;
`else
  assign rd_eligible = (state == IDLE) & buf_empty;
`endif

  assign rd_sel  = rd_pending & rd_eligible;
  assign wr_sel  = (state == IDLE) & ~rd_sel & ~buf_empty;
  assign push    = wr_gnt;
  assign pop     = wr_sel & mem_gnt_i;
  assign rd_resp = (state == RD_WAIT) & mem_rvalid_i;

  assign up_gnt_o    = wr_gnt | (rd_sel & mem_gnt_i);
  assign up_rvalid_o = wr_ack | rd_resp;
  assign up_rdata_o  = rd_resp ? mem_rdata_i : '0;
  assign wb_empty_o  = buf_empty & (state != WR_WAIT);

  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (rd_sel) begin
      mem_req_o  = 1'b1;
      mem_addr_o = up_addr_i;
      mem_be_o   = up_be_i;
    end else if (wr_sel) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = addr_mem[head];
      mem_be_o    = be_mem[head];
      mem_wdata_o = data_mem[head];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_gnt;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      unique case (state)
        IDLE: begin
          if (rd_sel && mem_gnt_i) state <= RD_WAIT;
          else if (pop)            state <= WR_WAIT;
        end
        RD_WAIT: if (mem_rvalid_i) state <= IDLE;
        WR_WAIT: if (mem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= up_addr_i;
      be_mem[tail]   <= up_be_i;
      data_mem[tail] <= up_wdata_i;
    end
  end

endmodule
